// File: rtl/logic_pkg.sv
// Shared types and defaults for the serial word loader and its shift core.
package logic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } ldr_state_t;

    localparam int LDR_W_DEFAULT = 8;

endpackage

// File: rtl/shift_in_core.sv
// MSB-first W-bit shift register plus frame bit counter, both with
// synchronous clear; sequencing is decided by the owning FSM.
module shift_in_core
    import logic_pkg::*;
#(
    parameter int W  = LDR_W_DEFAULT,
    parameter int CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          shift_i,
    input  logic          first_i,
    input  logic          inc_i,
    input  logic          bit_i,
    output logic [W-1:0]  sh_o,
    output logic [CW-1:0] cnt_o
);

    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state for shift register and counter; clear wins over shift/count.
    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sh_d  = {W{1'b0}};
            cnt_d = {CW{1'b0}};
        end else begin
            if (shift_i) begin
                sh_d = {sh_q[W-2:0], bit_i};
            end else begin
                sh_d = sh_q;
            end
            if (first_i) begin
                cnt_d = CW'(1);
            end else if (inc_i) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sh_q  <= {W{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign sh_o  = sh_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/serial_word_loader.sv
// Assembles an MSB-first serial frame and strobes the word into the downstream
// register stage via D/notE. Optional even-parity frame check: SERIAL_PARITY_EN.
module serial_word_loader
    import logic_pkg::*;
#(
    parameter int W = LDR_W_DEFAULT
) (
    input  logic         Clk,
    input  logic         notRst,
    input  logic         SerD,
    input  logic         SerV,
    output logic         SerRdy,
    output logic [W-1:0] D,
    output logic         notE,
    output logic         Busy,
    output logic         Err
);

`ifdef SERIAL_PARITY_EN
    localparam int NBITS = W + 1;
`else
    localparam int NBITS = W;
`endif
    localparam int CW = $clog2(W + 2);

    ldr_state_t    state_q, state_d;
    logic [W-1:0]  d_q, d_d;
    logic [W-1:0]  sh_s;
    logic [CW-1:0] cnt_s;
    logic          accept_s, last_s;
    logic          shift_s, first_s, inc_s, clr_s;
    logic          not_e_q, busy_q;

    assign accept_s = SerV & SerRdy;
    assign last_s   = (cnt_s == CW'(NBITS - 1));

`ifdef SERIAL_PARITY_EN
    logic perr_s;
    logic err_q;

    function automatic logic parity_err(input logic [W-1:0] data, input logic pbit);
        return ^{data, pbit};
    endfunction
`else
    // The final data bit is taken straight from SerD, so the core's MSB is never read.
    logic sh_msb_unused_s;
    assign sh_msb_unused_s = sh_s[W-1];
`endif

    shift_in_core #(
        .W  (W),
        .CW (CW)
    ) u_core (
        .clk_i   (Clk),
        .rst_n_i (notRst),
        .clr_i   (clr_s),
        .shift_i (shift_s),
        .first_i (first_s),
        .inc_i   (inc_s),
        .bit_i   (SerD),
        .sh_o    (sh_s),
        .cnt_o   (cnt_s)
    );

    // FSM next-state and core control.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        shift_s = 1'b0;
        first_s = 1'b0;
        inc_s   = 1'b0;
        clr_s   = 1'b0;
`ifdef SERIAL_PARITY_EN
        perr_s  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    shift_s = 1'b1;
                    first_s = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (accept_s && last_s) begin
`ifdef SERIAL_PARITY_EN
                    // Final bit is parity: sh already holds the full data word.
                    if (parity_err(sh_s, SerD)) begin
                        perr_s  = 1'b1;
                        clr_s   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        inc_s   = 1'b1;
                        d_d     = sh_s;
                        state_d = LOAD;
                    end
`else
                    shift_s = 1'b1;
                    inc_s   = 1'b1;
                    d_d     = {sh_s[W-2:0], SerD};
                    state_d = LOAD;
`endif
                end else if (accept_s) begin
                    shift_s = 1'b1;
                    inc_s   = 1'b1;
                end else begin
                    state_d = SHIFT;
                end
            end
            LOAD: begin
                clr_s   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                clr_s   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; strobe and Busy are derived from the next state.
    always_ff @(posedge Clk) begin
        if (!notRst) begin
            state_q <= IDLE;
            d_q     <= {W{1'b0}};
            not_e_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            not_e_q <= (state_d != LOAD);
            busy_q  <= (state_d != IDLE);
        end
    end

`ifdef SERIAL_PARITY_EN
    // One-cycle parity error pulse.
    always_ff @(posedge Clk) begin
        if (!notRst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= perr_s;
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    assign SerRdy = notRst & (state_q != LOAD);
    assign D      = d_q;
    assign notE   = not_e_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed self-checking bench for serial_word_loader (W=8); adds parity
// scenarios when SERIAL_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_serial_word_loader;
    import logic_pkg::*;

    localparam int W = LDR_W_DEFAULT;
`ifdef SERIAL_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         Clk = 1'b0;
    logic         notRst, SerD, SerV;
    logic         SerRdy, notE, Busy, Err;
    logic [W-1:0] D;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobes = 0;
    int strobe_cyc = 0;
    int prev_strobe_cyc = 0;
    int s0;

    always #5 Clk = ~Clk;

    serial_word_loader #(.W(W)) dut (
        .Clk    (Clk),
        .notRst (notRst),
        .SerD   (SerD),
        .SerV   (SerV),
        .SerRdy (SerRdy),
        .D      (D),
        .notE   (notE),
        .Busy   (Busy),
        .Err    (Err)
    );

    always @(posedge Clk) cyc <= cyc + 1;

    // Strobe monitor: counts notE-low cycles and remembers when they happened.
    always @(negedge Clk) begin
        if (notE === 1'b0) begin
            strobes         <= strobes + 1;
            prev_strobe_cyc <= strobe_cyc;
            strobe_cyc      <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [NB-1:0] mk(input logic [W-1:0] data);
`ifdef SERIAL_PARITY_EN
        return {data, ^data};
`else
        return data;
`endif
    endfunction

    // Sends one frame; returns just after the edge that accepts its last bit.
    task automatic send_frame(input logic [NB-1:0] frame, input int gap_a, input int gap_b);
        logic [W-1:0] d_before;
        d_before = D;
        for (int i = 0; i < NB; i++) begin
            SerV = 1'b1;
            SerD = frame[NB-1-i];
            #1 chk("rdy_before_accept", {31'd0, SerRdy}, 32'd1);
            tick();
            if (i != NB - 1) begin
                chk("no_early_strobe", {31'd0, notE}, 32'd1);
                chk("busy_mid_word", {31'd0, Busy}, 32'd1);
                chk("d_held_mid_word", {24'd0, D}, {24'd0, d_before});
                if (i == gap_a || i == gap_b) begin
                    SerV = 1'b0;
                    for (int g = 0; g < 3; g++) begin
                        SerD = 1'($urandom_range(0, 1));
                        tick();
                        chk("busy_in_gap", {31'd0, Busy}, 32'd1);
                        chk("no_strobe_in_gap", {31'd0, notE}, 32'd1);
                        chk("rdy_in_gap", {31'd0, SerRdy}, 32'd1);
                    end
                end
            end
        end
        SerV = 1'b0;
    endtask

    initial begin
        // Reset with random serial activity
        notRst = 1'b0;
        SerV   = 1'($urandom_range(0, 1));
        SerD   = 1'($urandom_range(0, 1));
        tick();
        SerV = 1'($urandom_range(0, 1));
        SerD = 1'($urandom_range(0, 1));
        tick();
        chk("rst_D", {24'd0, D}, 32'h0);
        chk("rst_notE", {31'd0, notE}, 32'd1);
        chk("rst_Busy", {31'd0, Busy}, 32'd0);
        chk("rst_Err", {31'd0, Err}, 32'd0);
        chk("rst_SerRdy", {31'd0, SerRdy}, 32'd0);
        notRst = 1'b1;
        SerV   = 1'b0;
        #1 chk("rdy_after_release", {31'd0, SerRdy}, 32'd1);

        // Reset mid-word discards four accepted ones
        for (int i = 0; i < 4; i++) begin
            SerV = 1'b1;
            SerD = 1'b1;
            tick();
        end
        chk("busy_partial", {31'd0, Busy}, 32'd1);
        SerV   = 1'b0;
        notRst = 1'b0;
        tick();
        chk("midrst_Busy", {31'd0, Busy}, 32'd0);
        chk("midrst_D", {24'd0, D}, 32'h0);
        chk("midrst_notE", {31'd0, notE}, 32'd1);
        notRst = 1'b1;
        send_frame(mk(8'h01), -1, -1);
        chk("w01_D", {24'd0, D}, 32'h01);
        chk("w01_notE", {31'd0, notE}, 32'd0);
        tick();
        chk("w01_notE_release", {31'd0, notE}, 32'd1);
        chk("w01_strobes", strobes, 32'd1);

        // Single word 0xB2
        s0 = strobes;
        send_frame(mk(8'hB2), -1, -1);
        chk("b2_D", {24'd0, D}, 32'hB2);
        chk("b2_notE", {31'd0, notE}, 32'd0);
        chk("b2_SerRdy_load", {31'd0, SerRdy}, 32'd0);
        chk("b2_Busy_load", {31'd0, Busy}, 32'd1);
        tick();
        chk("b2_notE_one_cycle", {31'd0, notE}, 32'd1);
        chk("b2_Busy_idle", {31'd0, Busy}, 32'd0);
        chk("b2_D_held", {24'd0, D}, 32'hB2);
        chk("b2_Err", {31'd0, Err}, 32'd0);
        chk("b2_strobes", strobes, s0 + 1);

        // Back-to-back 0xFF then 0x01 with SerV held high through LOAD
        s0 = strobes;
        send_frame(mk(8'hFF), -1, -1);
        chk("ff_D", {24'd0, D}, 32'hFF);
        chk("ff_notE", {31'd0, notE}, 32'd0);
        SerV = 1'b1;
        SerD = 1'b0;
        #1 chk("ff_rdy_low_in_load", {31'd0, SerRdy}, 32'd0);
        tick();
        chk("b2b_bit_not_taken", {31'd0, Busy}, 32'd0);
        chk("b2b_notE_release", {31'd0, notE}, 32'd1);
        send_frame(mk(8'h01), -1, -1);
        chk("b2b_01_D", {24'd0, D}, 32'h01);
        chk("b2b_01_notE", {31'd0, notE}, 32'd0);
        tick();
        chk("b2b_strobes", strobes, s0 + 2);
        chk("b2b_strobe_spacing", strobe_cyc - prev_strobe_cyc, NB + 1);

        // Gapped 0xB2: SerV low for 3 cycles after bits 2 and 5
        s0 = strobes;
        send_frame(mk(8'hB2), 1, 4);
        chk("gap_D", {24'd0, D}, 32'hB2);
        chk("gap_notE", {31'd0, notE}, 32'd0);
        tick();
        chk("gap_notE_release", {31'd0, notE}, 32'd1);
        chk("gap_strobes", strobes, s0 + 1);
        chk("gap_Err", {31'd0, Err}, 32'd0);

`ifdef SERIAL_PARITY_EN
        // Good parity loads; bad parity pulses Err and keeps D
        s0 = strobes;
        send_frame(mk(8'h01), -1, -1);
        chk("par_ok_D", {24'd0, D}, 32'h01);
        chk("par_ok_notE", {31'd0, notE}, 32'd0);
        chk("par_ok_Err", {31'd0, Err}, 32'd0);
        tick();
        send_frame(mk(8'hB2) ^ {{(NB-1){1'b0}}, 1'b1}, -1, -1);
        chk("par_bad_Err", {31'd0, Err}, 32'd1);
        chk("par_bad_notE", {31'd0, notE}, 32'd1);
        chk("par_bad_Busy", {31'd0, Busy}, 32'd0);
        chk("par_bad_D", {24'd0, D}, 32'h01);
        tick();
        chk("par_bad_Err_one_cycle", {31'd0, Err}, 32'd0);
        chk("par_bad_notE_after", {31'd0, notE}, 32'd1);
        chk("par_strobes", strobes, s0 + 1);
        send_frame(mk(8'hB2), -1, -1);
        chk("par_recover_D", {24'd0, D}, 32'hB2);
        chk("par_recover_notE", {31'd0, notE}, 32'd0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_loader.md
# serial_word_loader

Upstream feeder for the enable-gated D register stage. It assembles a serial bit stream into a W-bit word using a valid/ready handshake, then presents the word on a parallel `D` bus and drives the stage's active-low enable `notE` low for exactly one clock. Word capture is therefore a single, glitch-free strobe, with `D` held stable around it. This block owns all sequencing; the register stage downstream is purely storage.

## Interface
- `W`, default 8, data word width; legal range 2..32.
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `notRst`  in  1  reset, synchronous, active-low.
- `SerD`  in  1  serial data bit, MSB first.
- `SerV`  in  1  `SerD` valid.
- `SerRdy`  out  1  ready to accept a bit; a bit transfers on a rising edge with `SerV & SerRdy`.
- `D`  out  W  parallel word to the register stage.
- `notE`  out  1  active-low load strobe to the register stage.
- `Busy`  out  1  a word is in progress (state ≠ IDLE).
- `Err`  out  1  one-cycle parity error pulse; tied 0 unless `SERIAL_PARITY_EN` is defined.

## Operation
- FSM states are IDLE, SHIFT and LOAD. A bit counter `cnt` (width clog2(W+2)) and a shift register `sh[W-1:0]` support it.
- **IDLE:** `SerRdy=1`. An accepted bit sets `sh <= {sh[W-2:0],SerD}` and `cnt <= 1`, then moves to SHIFT.
- **SHIFT:** `SerRdy=1`. Each accepted bit shifts in the same way and sets `cnt <= cnt+1`.
  - The accept that completes the frame (`cnt` reaches `NBITS`) moves to LOAD.
  - `NBITS` = W, or W+1 with parity.
  - The same edge loads `D <= sh`, including the final bit.
- **LOAD:** `SerRdy=0` and `notE=0` for this cycle only. Next edge: `cnt <= 0`, go to IDLE.
- `SerV` low in any state means hold. There is no timeout, and `cnt` and `sh` are held.
- `notE=1` in every state except LOAD.
- `D` changes only on the edge that enters LOAD, and is otherwise held indefinitely.
- `SerRdy = notRst & (state != LOAD)`. This is the only combinational output.
- **Reset** (`notRst=0` at an edge), including mid-word:
  - state IDLE, `cnt=0`, `sh=0`, `D=0`, `notE=1`, `Err=0`.
  - `Busy=0` and `SerRdy=0` while `notRst` is low.
  - A partially shifted word is discarded.
  - Reset during LOAD cancels any further strobe. `notE` is 1 from that edge onward.

## Timing
- Last frame bit accepted at edge k: `D` valid and `notE=0` from edge k to edge k+1; `notE=1` again after edge k+1.
- `D` is stable for the whole low period of `notE`, and for at least one cycle before the next change.
- Minimum word period is W+1 cycles, or W+2 with parity. A bit offered during LOAD is not accepted and is held by the source.
- `Busy` is registered and equals `state != IDLE`.

## Configuration
- **`SERIAL_PARITY_EN` defined:**
  - The frame is W data bits plus one even-parity bit.
  - On the completing accept, if `^{sh_data, SerD}` is 0, behaviour is as above, with the parity bit not stored in `D`.
  - If it is 1, the FSM goes to IDLE instead of LOAD, `D` is unchanged, `notE` stays 1, and `Err=1` for the next cycle only.
- **Undefined:** the frame is W bits, no parity logic is built, and `Err` is constant 0.

## Structure
- Shared package `logic_pkg` holds:
  - the state enum `ldr_state_t` {IDLE, SHIFT, LOAD};
  - the constant `LDR_W_DEFAULT = 8`.
- One sub-module, `shift_in_core`, contains the W-bit MSB-first shift register with shift-enable and synchronous clear, plus the bit counter.
- FSM, output registers and parity check stay in `serial_word_loader`.

## Test plan
- **Reset:** hold `notRst=0` for 2 cycles with random `SerV`/`SerD` → `D=0`, `notE=1`, `Busy=0`, `Err=0`, `SerRdy=0`. Release → `SerRdy=1`.
- **Single word, W=8:** `SerV=1` with bits 1,0,1,1,0,0,1,0 on consecutive cycles → `D=8'hB2` after the 8th edge; `notE=0` for exactly one cycle; `SerRdy=0` in that cycle.
- **Gapped input:** same bits with `SerV` low for 3 cycles after bits 2 and 5 → identical `D=8'hB2` and a single one-cycle `notE` pulse; `Busy` high throughout.
- **Reset mid-word:** 4 bits of 0xFF, then `notRst=0` for 1 cycle → `D` stays 0 and there is no strobe. A following 0x01 → `D=8'h01`.
- **Back-to-back words:** 0xFF then 0x01 with `SerV` held high → the bit offered during LOAD is not taken; strobes are 9 cycles apart; `D` reads 0xFF then 0x01.
- **`SERIAL_PARITY_EN`:**
  - 0xB2 with parity bit 0 → load and `Err=0`.
  - 0xB2 with parity bit 1 → `Err` pulses for 1 cycle, `notE` stays 1, `D` keeps its previous value.
